stream_demux_1ton: RTL

//  Packet-aware 1-to-N stream demultiplexer, the splitting counterpart of the 2:1 select mux.
//  It routes a valid/ready byte stream to one of NUM_OUT destinations, registered, 1-cycle latency.
//  The destination is sampled on the first beat of each packet and held until the beat with in_last is accepted.

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/stream_demux_hold_reg.sv | 57 +++++
 rtl/stream_demux_1ton.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types for the packet-aware 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } demux_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/stream_demux_hold_reg.sv
// One-entry output holding register: loads an accepted beat, drains on downstream ready.
module stream_demux_hold_reg
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data_in,
  input  logic             last_in,
  input  logic [SEL_W-1:0] dst_in,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q,
  output logic             last_q,
  output logic [SEL_W-1:0] dst_q
);

  logic             vld_d;
  logic [WIDTH-1:0] data_d;
  logic             last_d;
  logic [SEL_W-1:0] dst_d;

  // A load wins over a drain so a same-cycle drain+load keeps the entry full.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    dst_d  = dst_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = data_in;
      last_d = last_in;
      dst_d  = dst_in;
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  // Entry storage; reset empties the entry and clears the visible data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      dst_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      dst_q  <= dst_d;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Packet-aware 1-to-N stream demux: select is locked per packet, bad selects are dropped.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  output logic [NUM_OUT-1:0]       out_last,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     err_sel
);

  localparam int SEL_SPAN = 1 << SEL_W;

  demux_state_t state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                err_sel_q, err_sel_d;
  logic                accept;
  logic                sel_ok;
  logic                load;
  logic [SEL_W-1:0]    load_dst;
  logic [SEL_SPAN-1:0] ready_ext;
  logic                hold_vld;
  logic [WIDTH-1:0]    hold_data;
  logic                hold_last;
  logic [SEL_W-1:0]    hold_dst;

  // Widen out_ready to the full select range so any dst value indexes safely.
  always_comb begin
    ready_ext              = '0;
    ready_ext[NUM_OUT-1:0] = out_ready;
  end

  // Handshake: DROP swallows everything; otherwise the entry must be empty or draining.
  always_comb begin
    in_ready = (state_q == DROP) || !hold_vld || ready_ext[hold_dst];
    accept   = in_valid && in_ready;
    sel_ok   = ({1'b0, in_sel} < (SEL_W + 1)'(NUM_OUT));
  end

  // Packet state register plus locked select and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      err_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      err_sel_q <= err_sel_d;
    end
  end

  // Next-state: a first beat picks BUSY or DROP unless it is also the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = sel_ok ? BUSY : DROP;
        end
      end
      BUSY, DROP: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: first beat uses in_sel directly, later beats use the locked select.
  always_comb begin
    load      = 1'b0;
    load_dst  = sel_q;
    sel_d     = sel_q;
    err_sel_d = 1'b0;
    case (state_q)
      IDLE: begin
        load_dst = in_sel;
        if (accept) begin
          if (sel_ok) begin
            load  = 1'b1;
            sel_d = in_sel;
          end else begin
            err_sel_d = 1'b1;
          end
        end
      end
      BUSY: begin
        load = accept;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  stream_demux_hold_reg #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .drain   (ready_ext[hold_dst]),
    .data_in (in_data),
    .last_in (in_last),
    .dst_in  (load_dst),
    .vld_q   (hold_vld),
    .data_q  (hold_data),
    .last_q  (hold_last),
    .dst_q   (hold_dst)
  );

  // Fan the single held beat out to every slice; only the dst slice is marked valid.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    out_data  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_valid[i]               = hold_vld && (hold_dst == SEL_W'(i));
      out_last[i]                = hold_last;
      out_data[i*WIDTH +: WIDTH] = hold_data;
    end
    err_sel = err_sel_q;
  end

endmodule
